// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared types for the SPI/local RAM arbiter
package spi_ram_pkg;
  typedef enum logic [1:0] {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11} spi_cmd_e;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} arb_state_e;
  typedef enum logic {SPI, LOC} owner_e;
endpackage

// File: rtl/spi_cmd_capture.sv
// spi_cmd_capture: SPI frame decode, address registers, single pending entry, overrun flag
module spi_cmd_capture
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  input  logic              spi_take,
  output logic              pend,
  output logic              pend_we,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [7:0]        pend_wdata,
  output logic              spi_ovr
);
  logic              rx_valid_q;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  spi_cmd_e          cmd;
  logic              frame, data_cmd;
  assign cmd      = spi_cmd_e'(rx_data[9:8]);
  assign frame    = rx_valid & ~rx_valid_q;
  assign data_cmd = frame & (cmd == WR_DATA || cmd == RD_DATA);
  // edge detect, address registers and pending entry; a grant on the same edge frees the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      pend       <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      spi_ovr    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (frame && cmd == WR_ADDR) wr_addr <= rx_data[ADDR_W-1:0];
      if (frame && cmd == RD_ADDR) rd_addr <= rx_data[ADDR_W-1:0];
      if (data_cmd && (!pend || spi_take)) begin
        pend       <= 1'b1;
        pend_we    <= cmd == WR_DATA;
        pend_addr  <= cmd == WR_DATA ? wr_addr : rd_addr;
        pend_wdata <= rx_data[7:0];
      end else if (spi_take) begin
        pend <= 1'b0;
      end
      if (data_cmd && pend && !spi_take) spi_ovr <= 1'b1;
    end
  end
endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin sharing of one RAM port between SPI commands and a local host
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  input  logic              ss_n,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic              loc_gnt,
  output logic [7:0]        loc_rdata,
  output logic              loc_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              spi_ovr
);
  arb_state_e        state, state_nx;
  owner_e            last_gnt;
  logic              cur_loc;
  logic              spi_pend, pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_wdata;
  logic              idle, pick_spi, pick_loc, grant, spi_take, capture;
  spi_cmd_capture #(.ADDR_W(ADDR_W)) u_cap (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .spi_take  (spi_take),
    .pend      (spi_pend),
    .pend_we   (pend_we),
    .pend_addr (pend_addr),
    .pend_wdata(pend_wdata),
    .spi_ovr   (spi_ovr)
  );
  // arbitration and next state; ram_we still holds the access type while in ACCESS
  always_comb begin
    idle     = state == IDLE;
    capture  = state == CAPTURE;
    pick_spi = spi_pend & (~loc_req | last_gnt == LOC);
    pick_loc = loc_req & ~pick_spi;
    grant    = idle & (spi_pend | loc_req);
    spi_take = idle & pick_spi;
    state_nx = idle ? (grant ? ACCESS : IDLE) : (state == ACCESS ? (ram_we ? IDLE : CAPTURE) : IDLE);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // RAM strobes, grant pulses, read-data return; last_gnt only moves on a contested grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      loc_gnt    <= 1'b0;
      loc_rdata  <= '0;
      loc_rvalid <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      cur_loc    <= 1'b0;
      last_gnt   <= LOC;
    end else begin
      ram_en     <= grant;
      ram_we     <= grant & (pick_spi ? pend_we : loc_we);
      loc_gnt    <= grant & pick_loc;
      loc_rvalid <= capture & cur_loc;
      if (grant) begin
        ram_addr  <= pick_spi ? pend_addr : loc_addr;
        ram_wdata <= pick_spi ? pend_wdata : loc_wdata;
        cur_loc   <= pick_loc;
      end
      if (grant && spi_pend && loc_req) last_gnt <= pick_loc ? LOC : SPI;
      if (capture && cur_loc) loc_rdata <= ram_rdata;
      if (capture && !cur_loc) begin
        tx_data  <= ram_rdata;
        tx_valid <= 1'b1;
      end else if (ss_n) begin
        tx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: vector table, corner sequences and randomized traffic against a memory model
module tb_spi_ram_arbiter;
  logic       clk = 0, rst = 1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 0, ss_n = 0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       loc_req = 0, loc_we = 0;
  logic [7:0] loc_addr = '0, loc_wdata = '0;
  logic       loc_gnt;
  logic [7:0] loc_rdata;
  logic       loc_rvalid, ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       spi_ovr;
  int         errors = 0, checks = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  spi_ram_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .ss_n(ss_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .loc_req(loc_req), .loc_we(loc_we),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_gnt(loc_gnt), .loc_rdata(loc_rdata),
    .loc_rvalid(loc_rvalid), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .spi_ovr(spi_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    bit         spi;
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic all_zero(input string name);
    chk(name, 64'({tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid, ram_en, ram_we, ram_addr, ram_wdata, spi_ovr}), 64'(0));
  endtask

  task automatic spi_frame(input logic [9:0] f);
    rx_data = f;
    rx_valid = 1;
    tick();
    rx_valid = 0;
    tick();
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    spi_frame({2'b00, a});
    rx_data = {2'b01, d};
    rx_valid = 1;
    tick();
    rx_valid = 0;
    tick();
    chk("spi_wr_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({2'b11, a, d}));
    tick();
    chk("spi_wr_end", 64'({ram_en, tx_valid}), 64'(0));
    ref_mem[a] = d;
  endtask

  task automatic spi_read(input logic [7:0] a, input logic [7:0] exp);
    spi_frame({2'b10, a});
    rx_data = {2'b11, 8'h00};
    rx_valid = 1;
    tick();
    rx_valid = 0;
    tick();
    chk("spi_rd_ram", 64'({ram_en, ram_we, ram_addr}), 64'({2'b10, a}));
    tick();
    tick();
    chk("spi_rd_tx", 64'({tx_valid, tx_data}), 64'({1'b1, exp}));
    ss_n = 1;
    tick();
    chk("spi_rd_txdrop", 64'(tx_valid), 64'(0));
    ss_n = 0;
  endtask

  task automatic loc_op(input bit we, input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp);
    loc_req = 1;
    loc_we = we;
    loc_addr = a;
    loc_wdata = d;
    tick();
    if (we) chk("loc_wr_gnt", 64'({loc_gnt, ram_en, ram_we, ram_addr, ram_wdata}), 64'({3'b111, a, d}));
    else chk("loc_rd_gnt", 64'({loc_gnt, ram_en, ram_we, ram_addr}), 64'({3'b110, a}));
    loc_req = 0;
    tick();
    chk("loc_gnt_pulse", 64'({loc_gnt, ram_en}), 64'(0));
    if (!we) begin
      tick();
      chk("loc_rd_data", 64'({loc_rvalid, loc_rdata}), 64'({1'b1, exp}));
      tick();
      chk("loc_rvalid_pulse", 64'(loc_rvalid), 64'(0));
    end else begin
      ref_mem[a] = d;
    end
  endtask

  task automatic apply(input bit spi, input bit we, input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp);
    if (spi && we) spi_write(a, d);
    else if (spi) spi_read(a, exp);
    else loc_op(we, a, d, exp);
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 1, 8'h12, 8'hA5, 8'h00};
    tbl[1] = '{1, 0, 8'h12, 8'h00, 8'hA5};
    tbl[2] = '{0, 1, 8'h40, 8'h05, 8'h00};
    tbl[3] = '{0, 0, 8'h40, 8'h00, 8'h05};
    tbl[4] = '{0, 1, 8'h00, 8'h3C, 8'h00};
    tbl[5] = '{1, 0, 8'h00, 8'h00, 8'h3C};
    tbl[6] = '{1, 1, 8'hFF, 8'h81, 8'h00};
    tbl[7] = '{0, 0, 8'hFF, 8'h00, 8'h81};
    do_reset();
    all_zero("reset_outputs");
    for (int i = 0; i < 8; i++) apply(tbl[i].spi, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp);
    // read with rx_valid held six cycles: one access, tx held until ss_n
    spi_frame({2'b10, 8'h12});
    rx_data = {2'b11, 8'h00};
    rx_valid = 1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ram_en) n++;
      if (i == 2) chk("hold_rd_ram", 64'({ram_en, ram_we, ram_addr}), 64'({2'b10, 8'h12}));
      if (i == 3) chk("hold_tx_early", 64'(tx_valid), 64'(0));
      if (i == 4) chk("hold_tx", 64'({tx_valid, tx_data}), 64'({1'b1, 8'hA5}));
      if (i == 6) rx_valid = 0;
    end
    chk("hold_one_read", 64'(n), 64'(1));
    chk("hold_tx_kept", 64'({tx_valid, tx_data}), 64'({1'b1, 8'hA5}));
    ss_n = 1;
    tick();
    chk("hold_tx_drop", 64'(tx_valid), 64'(0));
    ss_n = 0;
    // simultaneous SPI and local: SPI first after reset, local first on the next tie
    do_reset();
    for (int k = 0; k < 2; k++) begin
      spi_frame({2'b00, 8'h30 + 8'(k)});
      rx_data = {2'b01, 8'h77 + 8'(k)};
      rx_valid = 1;
      tick();
      rx_valid = 0;
      loc_req = 1;
      loc_we = 1;
      loc_addr = 8'h40;
      loc_wdata = 8'h05;
      tick();
      if (k == 0) begin
        chk("tie1_spi_first", 64'({loc_gnt, ram_en, ram_addr, ram_wdata}), 64'({2'b01, 8'h30, 8'h77}));
        tick();
        chk("tie1_gap", 64'(ram_en), 64'(0));
        tick();
        chk("tie1_loc_next", 64'({loc_gnt, ram_en, ram_addr}), 64'({2'b11, 8'h40}));
        loc_req = 0;
      end else begin
        chk("tie2_loc_first", 64'({loc_gnt, ram_en, ram_addr}), 64'({2'b11, 8'h40}));
        loc_req = 0;
        tick();
        tick();
        chk("tie2_spi_next", 64'({loc_gnt, ram_en, ram_addr, ram_wdata}), 64'({2'b01, 8'h31, 8'h78}));
      end
      tick();
      tick();
      ref_mem[8'h30 + 8'(k)] = 8'h77 + 8'(k);
      ref_mem[8'h40] = 8'h05;
    end
    spi_read(8'h31, ref_mem[8'h31]);
    // overrun: two write frames while a local read occupies the port
    spi_frame({2'b00, 8'h50});
    loc_req = 1;
    loc_we = 0;
    loc_addr = 8'h40;
    rx_data = {2'b01, 8'hAA};
    rx_valid = 1;
    tick();
    chk("ovr_loc_gnt", 64'({loc_gnt, spi_ovr}), 64'({2'b10}));
    loc_req = 0;
    rx_valid = 0;
    tick();
    rx_data = {2'b01, 8'hBB};
    rx_valid = 1;
    tick();
    chk("ovr_flag", 64'(spi_ovr), 64'(1));
    chk("ovr_loc_rdata", 64'({loc_rvalid, loc_rdata}), 64'({1'b1, ref_mem[8'h40]}));
    rx_valid = 0;
    tick();
    chk("ovr_first_wr", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({2'b11, 8'h50, 8'hAA}));
    ref_mem[8'h50] = 8'hAA;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ram_en) n++;
    end
    chk("ovr_dropped", 64'(n), 64'(0));
    chk("ovr_sticky", 64'(spi_ovr), 64'(1));
    spi_read(8'h50, 8'hAA);
    // randomized isolated traffic checked against the memory model
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a;
      a = i < 8 ? 8'(i) : 8'hF0 | 8'(i);
      apply(1'($urandom_range(0, 1)), 1, a, 8'($urandom), 8'h00);
    end
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      int r;
      bit s, w;
      r = $urandom_range(0, 15);
      a = r < 8 ? 8'(r) : 8'hF0 | 8'(r);
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      apply(s, w, a, 8'($urandom), ref_mem[a]);
    end
    // reset during the capture cycle of an SPI read
    spi_frame({2'b10, 8'h12});
    rx_data = {2'b11, 8'h00};
    rx_valid = 1;
    tick();
    rx_valid = 0;
    tick();
    chk("rst_rd_ram", 64'({ram_en, ram_addr}), 64'({1'b1, 8'h12}));
    tick();
    rst = 1;
    tick();
    all_zero("rst_mid_outputs");
    rst = 0;
    tick();
    chk("rst_mid_quiet", 64'({tx_valid, ram_en}), 64'(0));
    loc_op(1, 8'h66, 8'h99, 8'h00);
    loc_op(0, 8'h66, 8'h00, 8'h99);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Owns the single-port RAM port and shares it between the SPI slave command stream (10-bit frames, rx_data/rx_valid) and a local host port (req/gnt). Decodes SPI frame bits [9:8], holds the SPI write/read address registers, and returns SPI read data on tx_data/tx_valid. Round-robin arbitration. The RAM has no backpressure and a 1-cycle synchronous read.

Parameters:
ADDR_W, 8, RAM address width (1..8); SPI addresses use rx_data[ADDR_W-1:0].

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx_data  in  10  SPI frame: [9:8] cmd, [7:0] payload
rx_valid  in  1  level from slave; frame accepted on its rising edge only
ss_n  in  1  SPI slave-select; ends tx_valid hold
tx_data  out  8  SPI read data
tx_valid  out  1  SPI read data valid (held)
loc_req  in  1  local request; held until loc_gnt
loc_we  in  1  local 1=write, 0=read
loc_addr  in  ADDR_W  local address
loc_wdata  in  8  local write data
loc_gnt  out  1  1-cycle accept pulse
loc_rdata  out  8  local read data
loc_rvalid  out  1  1-cycle read-data pulse
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data, valid the cycle after ram_en & ~ram_we
spi_ovr  out  1  sticky SPI overrun flag

Behaviour:
- Reset: all outputs 0; wr_addr/rd_addr = 0; pending cleared; state IDLE; last_gnt = LOC, so SPI wins the first tie.
- Edge detect: a new frame is accepted when rx_valid=1 and rx_valid_q=0. A level held over many cycles gives exactly one frame.
- Command 00: wr_addr <= payload. Command 10: rd_addr <= payload. Neither touches the RAM.
- Command 01: load the pending entry {wr, wr_addr, payload}.
- Command 11: load the pending entry {rd, rd_addr}.
- Pending conflict:
  - Command 01/11 accepted while pending is still set: set spi_ovr, drop the new frame, keep the old entry.
  - Pending granted in the same edge a new 01/11 arrives: set wins, no overrun.
- Address commands take effect immediately; an already-pending entry keeps its captured address.
- FSM IDLE:
  - Candidates are spi_pend and loc_req.
  - With both present, grant the side opposite last_gnt, then update last_gnt.
  - Grant edge registers ram_en=1, ram_we, ram_addr and ram_wdata, and goes to ACCESS.
  - A local grant also registers loc_gnt=1 for that one cycle.
  - An SPI grant clears spi_pend.
- FSM ACCESS (1 cycle):
  - ram_en/ram_we return to 0 next edge.
  - Write: go to IDLE.
  - Read: go to CAPTURE.
- FSM CAPTURE (1 cycle):
  - Latch ram_rdata.
  - SPI read: tx_data <= ram_rdata, tx_valid <= 1.
  - Local read: loc_rdata <= ram_rdata, loc_rvalid pulses 1 cycle.
  - Go to IDLE.
- Latency, uncontended, from the first rx_valid-high cycle C:
  - ram_en high in cycle C+2.
  - SPI tx_valid high from C+4.
  - Local: loc_gnt and ram_en high the cycle after loc_req is seen in IDLE; loc_rvalid 2 cycles later.
- Occupancy: write = 2 cycles, read = 3 cycles; IDLE is re-entered between accesses.
- tx_valid hold: stays 1 and tx_data stable until ss_n sampled 1; tx_valid = 0 the next cycle. A new SPI read capture reloads both.
- Local requester rule: loc_req must drop within 1 cycle of loc_gnt, otherwise it is re-granted as a new request.
- spi_ovr clears only on rst.
- Reset mid-operation: any state returns to IDLE; ram_en, loc_gnt, loc_rvalid and tx_valid are 0 next cycle; the pending entry and in-flight read data are discarded.

Decomposition:
- Package spi_ram_pkg:
  - spi_cmd_e: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
  - arb_state_e: IDLE, ACCESS, CAPTURE.
  - owner_e: SPI, LOC.
- Sub-module spi_cmd_capture: rx_valid edge detect, frame decode, wr_addr/rd_addr registers, single pending entry, spi_ovr.
- Arbiter FSM and RAM output registers stay in the top level.

Test Plan:
1. SPI 0x012 then 0x1A5 (rising edge each) -> one cycle of ram_en=1, ram_we=1, ram_addr=0x12, ram_wdata=0xA5, two cycles after the second edge; no tx_valid.
2. RAM[0x12]=0xA5; SPI 0x212, then 0x300 with rx_valid held 6 cycles -> exactly one read, ram_addr=0x12; tx_valid=1, tx_data=0xA5 from C+4; tx_valid held until ss_n=1, low the cycle after.
3. After reset, spi_pend and loc_req (write 0x05 to addr 0x40) become valid the same cycle -> SPI access first, then loc_gnt. A second simultaneous tie -> local first.
4. loc_req read addr 0x40 (holds 0x05), no SPI traffic -> loc_gnt then loc_rvalid=1, loc_rdata=0x05 two cycles later.
5. Local read busy, then SPI 0x1AA and 0x1BB on consecutive rising edges before the first is granted -> spi_ovr=1; only 0xAA is written.
6. rst asserted during CAPTURE of an SPI read -> tx_valid stays 0, state IDLE next cycle, all outputs 0.
